dds_drg_emulator: RTL and testbench
===================================

Name: dds_drg_emulator

Overview:
- Cycle-level responder model of the AD9910 digital ramp generator (DRG) in the FPGA fabric.
- Consumes the FPGA-side ramp controls (drctl, drhold) and the io_update strobe, and runs a ramp accumulator between programmable limits.
- Drives drover back, so the chirp trigger/OSK timing logic can be closed-loop tested on hardware without a DDS fitted, and the DRG can be mirrored for monitoring.
- Sits beside the DDS timing controller, with the same 500 MHz sys_clk.

Parameters:
- WIDTH, 16, accumulator, limit and step width in bits.
- RATE_W, 16, rate-divider width in bits.

Ports:
- sys_clk  in  1  system clock, 500 MHz.
- sys_rst  in  1  synchronous reset, active-high.
- drg_enable  in  1  DRG enable; 0 forces IDLE.
- io_update  in  1  configuration load strobe; the rising edge is the active event.
- cfg_lower  in  WIDTH  lower ramp limit.
- cfg_upper  in  WIDTH  upper ramp limit.
- cfg_step_up  in  WIDTH  positive step size.
- cfg_step_down  in  WIDTH  negative step size.
- cfg_rate_up  in  RATE_W  clocks per up-step, minus 1.
- cfg_rate_down  in  RATE_W  clocks per down-step, minus 1.
- drctl  in  1  ramp direction: 1 = up, 0 = down.
- drhold  in  1  freezes the ramp while high.
- drover  out  1  high while the accumulator sits at the limit for the current direction.
- ramp_value  out  WIDTH  accumulator value.
- cfg_error  out  1  latched config has cfg_lower > cfg_upper.

Behaviour:
- **Reset (sys_rst=1).** Sets ramp_value=0, drover=0, cfg_error=0, all shadow config registers = 0, rate counter = 0, state = IDLE, and the edge-detect registers = 0. Reset asserted mid-ramp aborts the ramp at the next edge.
- **Input registration.** io_update, drctl and drhold each pass through a 2-stage shift register. Edge and level decisions use stage [1]; stage [0] is used only for the io_update edge.
- **Config load.** On the io_update rising edge (~[1] & [0]), all cfg_* inputs are copied into shadow registers in that cycle.
  - The accumulator is set to cfg_lower and the rate counter is cleared.
  - The state goes to AT_LOWER if cfg_lower <= cfg_upper, else to ERROR.
  - This load overrides every other event in that cycle, including drhold.
- **States.**
  - IDLE: ramp_value is held; drover=0. Exits to AT_LOWER on a config load while drg_enable=1.
  - AT_LOWER: if drctl=1, go to RAMP_UP.
  - RAMP_UP: step up on each rate tick. When the clamped result equals the upper limit, go to AT_UPPER. If drctl=0, go to RAMP_DOWN with the rate counter cleared.
  - AT_UPPER: if drctl=0, go to RAMP_DOWN.
  - RAMP_DOWN: the mirror of RAMP_UP, ending in AT_LOWER.
  - ERROR: cfg_error=1; ramp_value is held at the shadow lower limit; drover=0. Exits only on a valid config load.
  - drg_enable=0 in any state goes to IDLE on the next cycle.
- **Rate tick.** The rate counter counts 0..rate for the active direction; a step occurs when count == rate, and the counter then wraps to 0. rate=0 gives a step every clock. The counter is cleared on every state change.
- **Arithmetic.** Sums are formed in WIDTH+1 bits.
  - Up: if acc + step >= upper, the next value is upper.
  - Down: if acc < lower + step (WIDTH+1 compare), the next value is lower.
  - No wrap-around is ever produced.
  - step=0 means ramp_value never moves. drover goes high only if the accumulator already equals the target limit (e.g. lower == upper).
- **drover.** Registered, 1 = (state==AT_UPPER & drctl=1) | (state==AT_LOWER & drctl=0). It asserts in the same cycle ramp_value first shows the limit.
  - A drctl reversal while at the limit drops drover one cycle after the registered drctl changes.
  - The first step away from the limit occurs rate+1 clocks later.
- **drhold=1.** Freezes the accumulator, rate counter and state; drover keeps its value. Release resumes counting from the frozen count.
- **Latency.** Pin to stage [1] is 2 clocks; a step, once ticked, is visible on ramp_value 1 clock later.
- **Simultaneous events.** Config load beats drg_enable=0 only if drg_enable=1 in that cycle. drhold beats a drctl reversal; the reversal is applied on release.

Test Plan:
1. Reset, then io_update pulse with lower=100, upper=120, step_up=5, rate_up=0, drctl=1 → ramp_value 100,105,110,115,120 on consecutive clocks; drover rises with 120 and stays high.
2. Same config, then drctl=0 with step_down=7, rate_down=3 → ramp_value steps every 4 clocks: 120,113,106,100 (clamped). drover falls, then rises at 100.
3. Mid-ramp drhold=1 for 10 clocks at value 110 → ramp_value and drover constant; after release, the next step lands exactly rate+1 clocks after the freeze point.
4. Load lower=200, upper=50 → cfg_error=1, ramp_value=200, drover=0 under drctl toggling; a valid reload clears cfg_error.
5. Near-overflow: lower=0xFFF0, upper=0xFFFF, step=0x20 → a single step clamps to 0xFFFF, with no wrap to a small value.
6. sys_rst=1 during RAMP_UP → next cycle ramp_value=0, drover=0, IDLE; no motion until drg_enable=1 and a new io_update.

Source files
------------

// File: rtl/dds_drg_emulator.sv
// Cycle-level model of the AD9910 digital ramp generator (DRG).
// It registers the ramp control pins, runs a clamped ramp accumulator between
// shadow-loaded limits and drives drover back to the FPGA timing logic.
module dds_drg_emulator #(
  parameter int WIDTH  = 16,
  parameter int RATE_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              drg_enable,
  input  logic              io_update,
  input  logic [WIDTH-1:0]  cfg_lower,
  input  logic [WIDTH-1:0]  cfg_upper,
  input  logic [WIDTH-1:0]  cfg_step_up,
  input  logic [WIDTH-1:0]  cfg_step_down,
  input  logic [RATE_W-1:0] cfg_rate_up,
  input  logic [RATE_W-1:0] cfg_rate_down,
  input  logic              drctl,
  input  logic              drhold,
  output logic              drover,
  output logic [WIDTH-1:0]  ramp_value,
  output logic              cfg_error
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AT_LOWER  = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_AT_UPPER  = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  logic [1:0]        iou_sync_q, drctl_sync_q, drhold_sync_q;
  logic [WIDTH-1:0]  lower_q, upper_q, step_up_q, step_down_q;
  logic [RATE_W-1:0] rate_up_q, rate_down_q;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              drover_q, drover_d;
  logic              cfg_error_q, cfg_error_d;

  logic              load_s, dir_up_s, hold_s, tick_s;
  logic [RATE_W-1:0] rate_s;
  logic [WIDTH:0]    sum_up_s, floor_dn_s;
  logic [WIDTH-1:0]  next_up_s, next_dn_s;

  // Two-stage input registers; stage [0] is the newest sample.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      iou_sync_q    <= 2'b00;
      drctl_sync_q  <= 2'b00;
      drhold_sync_q <= 2'b00;
    end else begin
      iou_sync_q    <= {iou_sync_q[0], io_update};
      drctl_sync_q  <= {drctl_sync_q[0], drctl};
      drhold_sync_q <= {drhold_sync_q[0], drhold};
    end
  end

  assign load_s   = iou_sync_q[0] & ~iou_sync_q[1];
  assign dir_up_s = drctl_sync_q[1];
  assign hold_s   = drhold_sync_q[1];

  // Shadow configuration captured on every io_update rising edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lower_q     <= {WIDTH{1'b0}};
      upper_q     <= {WIDTH{1'b0}};
      step_up_q   <= {WIDTH{1'b0}};
      step_down_q <= {WIDTH{1'b0}};
      rate_up_q   <= {RATE_W{1'b0}};
      rate_down_q <= {RATE_W{1'b0}};
    end else if (load_s) begin
      lower_q     <= cfg_lower;
      upper_q     <= cfg_upper;
      step_up_q   <= cfg_step_up;
      step_down_q <= cfg_step_down;
      rate_up_q   <= cfg_rate_up;
      rate_down_q <= cfg_rate_down;
    end
  end

  // Rate selection and clamped step arithmetic, one bit wider than the data.
  always_comb begin
    rate_s     = (state_q == ST_RAMP_DOWN) ? rate_down_q : rate_up_q;
    tick_s     = (cnt_q == rate_s);
    sum_up_s   = {1'b0, acc_q} + {1'b0, step_up_q};
    floor_dn_s = {1'b0, lower_q} + {1'b0, step_down_q};
    if (sum_up_s >= {1'b0, upper_q}) begin
      next_up_s = upper_q;
    end else begin
      next_up_s = sum_up_s[WIDTH-1:0];
    end
    if ({1'b0, acc_q} < floor_dn_s) begin
      next_dn_s = lower_q;
    end else begin
      next_dn_s = acc_q - step_down_q;
    end
  end

  // Ramp FSM next state, accumulator, rate counter and registered flags.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (load_s && drg_enable) begin
      acc_d   = cfg_lower;
      cnt_d   = {RATE_W{1'b0}};
      state_d = (cfg_lower <= cfg_upper) ? ST_AT_LOWER : ST_ERROR;
    end else if (!drg_enable) begin
      state_d = ST_IDLE;
    end else if (hold_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_IDLE;
        ST_ERROR:    state_d = ST_ERROR;
        ST_AT_LOWER: if (dir_up_s) state_d = ST_RAMP_UP; else state_d = ST_AT_LOWER;
        ST_AT_UPPER: if (!dir_up_s) state_d = ST_RAMP_DOWN; else state_d = ST_AT_UPPER;
        ST_RAMP_UP: begin
          if (!dir_up_s) begin
            state_d = ST_RAMP_DOWN;
          end else if (tick_s) begin
            acc_d = next_up_s;
            cnt_d = {RATE_W{1'b0}};
            if (next_up_s == upper_q) state_d = ST_AT_UPPER; else state_d = ST_RAMP_UP;
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        ST_RAMP_DOWN: begin
          if (dir_up_s) begin
            state_d = ST_RAMP_UP;
          end else if (tick_s) begin
            acc_d = next_dn_s;
            cnt_d = {RATE_W{1'b0}};
            if (next_dn_s == lower_q) state_d = ST_AT_LOWER; else state_d = ST_RAMP_DOWN;
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Every state change restarts the step interval.
    if (state_d != state_q) begin
      cnt_d = {RATE_W{1'b0}};
    end else begin
      cnt_d = cnt_d;
    end
    // A frozen ramp keeps drover as it was, whatever drctl does meanwhile.
    if (drg_enable && !load_s && hold_s) begin
      drover_d = drover_q;
    end else begin
      drover_d = ((state_d == ST_AT_UPPER) && dir_up_s) ||
                 ((state_d == ST_AT_LOWER) && !dir_up_s);
    end
    cfg_error_d = (state_d == ST_ERROR);
  end

  // State, accumulator, counter and output flag registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {RATE_W{1'b0}};
      drover_q    <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      drover_q    <= drover_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign ramp_value = acc_q;
  assign drover     = drover_q;
  assign cfg_error  = cfg_error_q;

endmodule

// File: tb/tb_dds_drg_emulator.sv
// Self-checking bench for dds_drg_emulator: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural ramp model.
module tb_dds_drg_emulator;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        drg_enable = 1'b0;
  logic        io_update = 1'b0;
  logic [15:0] cfg_lower = 16'd0, cfg_upper = 16'd0;
  logic [15:0] cfg_step_up = 16'd0, cfg_step_down = 16'd0;
  logic [15:0] cfg_rate_up = 16'd0, cfg_rate_down = 16'd0;
  logic        drctl = 1'b0, drhold = 1'b0;
  logic        drover;
  logic [15:0] ramp_value;
  logic        cfg_error;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0 idle, 1 error, 2 parked at a limit, 3 moving.
  // m_up gives the direction of motion, or which limit it is parked on.
  int m_mode, m_up, m_acc, m_cnt, m_drover, m_err;
  int s_lo, s_hi, s_su, s_sd, s_ru, s_rd;
  int p_iou1, p_iou2, p_ctl1, p_ctl2, p_hold1, p_hold2;

  dds_drg_emulator #(.WIDTH(16), .RATE_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .drg_enable(drg_enable),
    .io_update(io_update), .cfg_lower(cfg_lower), .cfg_upper(cfg_upper),
    .cfg_step_up(cfg_step_up), .cfg_step_down(cfg_step_down),
    .cfg_rate_up(cfg_rate_up), .cfg_rate_down(cfg_rate_down),
    .drctl(drctl), .drhold(drhold), .drover(drover),
    .ramp_value(ramp_value), .cfg_error(cfg_error)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_mode = 0; m_up = 0; m_acc = 0; m_cnt = 0; m_drover = 0; m_err = 0;
    s_lo = 0; s_hi = 0; s_su = 0; s_sd = 0; s_ru = 0; s_rd = 0;
    p_iou1 = 0; p_iou2 = 0; p_ctl1 = 0; p_ctl2 = 0; p_hold1 = 0; p_hold2 = 0;
  endtask

  // One clock of the ramp rules, using pin values seen two clocks late.
  task automatic model_step();
    int ctl, hold, load, nv, keep;
    if (sys_rst) begin
      model_reset();
      return;
    end
    ctl = p_ctl2; hold = p_hold2; load = (p_iou1 == 1 && p_iou2 == 0);
    keep = 0;
    if (load) begin
      s_lo = cfg_lower; s_hi = cfg_upper; s_su = cfg_step_up;
      s_sd = cfg_step_down; s_ru = cfg_rate_up; s_rd = cfg_rate_down;
    end
    if (load && drg_enable) begin
      m_acc = cfg_lower; m_cnt = 0; m_up = 0;
      m_mode = (int'(cfg_lower) <= int'(cfg_upper)) ? 2 : 1;
    end else if (!drg_enable) begin
      m_mode = 0; m_cnt = 0;
    end else if (hold) begin
      keep = 1;
    end else if (m_mode == 2) begin
      if (m_up != ctl) begin m_mode = 3; m_up = ctl; m_cnt = 0; end
    end else if (m_mode == 3) begin
      if (m_up != ctl) begin
        m_up = ctl; m_cnt = 0;
      end else if (m_cnt == (m_up ? s_ru : s_rd)) begin
        m_cnt = 0;
        if (m_up) begin
          nv = (m_acc + s_su > s_hi) ? s_hi : m_acc + s_su;
          if (nv == s_hi) m_mode = 2;
        end else begin
          nv = (m_acc - s_sd < s_lo) ? s_lo : m_acc - s_sd;
          if (nv == s_lo) m_mode = 2;
        end
        m_acc = nv;
      end else begin
        m_cnt++;
      end
    end
    if (!keep) m_drover = (m_mode == 2) && (m_up ? ctl == 1 : ctl == 0);
    m_err = (m_mode == 1);
    p_iou2 = p_iou1; p_iou1 = io_update;
    p_ctl2 = p_ctl1; p_ctl1 = drctl;
    p_hold2 = p_hold1; p_hold1 = drhold;
  endtask

  function automatic logic [17:0] model_vec();
    return {m_err != 0, m_drover != 0, 16'(m_acc)};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input int lo, hi, su, sd, ru, rd);
    cfg_lower = 16'(lo); cfg_upper = 16'(hi); cfg_step_up = 16'(su);
    cfg_step_down = 16'(sd); cfg_rate_up = 16'(ru); cfg_rate_down = 16'(rd);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({cfg_error, drover, ramp_value} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset: got %h expected %h", {cfg_error, drover, ramp_value}, 18'd0);
    end
    sys_rst = 1'b0;
    drg_enable = 1'b1;
    tick();
  endtask

  task automatic test_ramp_up();
    set_cfg(100, 120, 5, 7, 0, 3);
    drctl = 1'b1;
    io_update = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      io_update = 1'b0;
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL ramp_up cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
    n_checks++;
    if (ramp_value !== 16'd120 || drover !== 1'b1) begin
      n_errors++;
      $display("FAIL ramp_up_end: got %0d/%b expected 120/1", ramp_value, drover);
    end
  endtask

  task automatic test_ramp_down();
    drctl = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL ramp_down cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
    n_checks++;
    if (ramp_value !== 16'd100 || drover !== 1'b1) begin
      n_errors++;
      $display("FAIL ramp_down_end: got %0d/%b expected 100/1", ramp_value, drover);
    end
  endtask

  task automatic test_hold();
    int found;
    found = 0;
    set_cfg(100, 120, 5, 7, 3, 3);
    drctl = 1'b1;
    io_update = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      io_update = 1'b0;
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL hold_pre cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
      if (m_acc == 110 && m_mode == 3) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL hold_reach: got no value 110 within 40 cycles, expected 110");
    end
    drhold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (ramp_value !== 16'd110 || {cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL hold_frozen cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
    drhold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL hold_release cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
  endtask

  task automatic test_error();
    set_cfg(200, 50, 5, 5, 0, 0);
    io_update = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      io_update = 1'b0;
      if (i % 3 == 2) drctl = ~drctl;
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL error cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
    n_checks++;
    if (cfg_error !== 1'b1 || ramp_value !== 16'd200 || drover !== 1'b0) begin
      n_errors++;
      $display("FAIL error_state: got %b/%0d/%b expected 1/200/0", cfg_error, ramp_value, drover);
    end
    set_cfg(10, 40, 5, 5, 0, 0);
    io_update = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      io_update = 1'b0;
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL error_reload cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
    n_checks++;
    if (cfg_error !== 1'b0) begin
      n_errors++;
      $display("FAIL error_clear: got %b expected 0", cfg_error);
    end
  endtask

  task automatic test_overflow();
    set_cfg(16'hFFF0, 16'hFFFF, 16'h20, 16'h20, 0, 0);
    drctl = 1'b1;
    io_update = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      io_update = 1'b0;
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL overflow cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
    n_checks++;
    if (ramp_value !== 16'hFFFF || drover !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_clamp: got %h/%b expected ffff/1", ramp_value, drover);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(0, 1000, 3, 3, 1, 1);
    drctl = 1'b1;
    io_update = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      io_update = 1'b0;
    end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    n_checks++;
    if ({cfg_error, drover, ramp_value} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got %h expected %h", {cfg_error, drover, ramp_value}, 18'd0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (ramp_value !== 16'd0 || {cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL reset_idle cyc %0d: got %h expected 0", i, {cfg_error, drover, ramp_value});
      end
    end
    io_update = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      io_update = 1'b0;
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL reset_restart cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
  endtask

  task automatic test_random();
    int lo, hi;
    for (int i = 0; i < 4000; i++) begin
      io_update = 1'b0;
      sys_rst = 1'b0;
      if ($urandom_range(0, 99) < 3) begin
        lo = $urandom_range(0, 65535);
        if ($urandom_range(0, 99) < 85) begin
          hi = lo + $urandom_range(0, 2000);
          if (hi > 65535) hi = 65535;
        end else begin
          hi = $urandom_range(0, 65535);
        end
        set_cfg(lo, hi, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 400),
                $urandom_range(0, 400), $urandom_range(0, 3), $urandom_range(0, 3));
        io_update = 1'b1;
      end
      if ($urandom_range(0, 99) < 5) drctl = ~drctl;
      if ($urandom_range(0, 99) < 4) drhold = ~drhold;
      if (drg_enable && $urandom_range(0, 199) == 0) drg_enable = 1'b0;
      else if (!drg_enable && $urandom_range(0, 9) == 0) drg_enable = 1'b1;
      if ($urandom_range(0, 499) == 0) sys_rst = 1'b1;
      tick();
      n_checks++;
      if ({cfg_error, drover, ramp_value} !== model_vec()) begin
        n_errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, {cfg_error, drover, ramp_value}, model_vec());
      end
    end
    sys_rst = 1'b0;
    io_update = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_hold();
    test_error();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
